ahb_sram_slave: RTL and testbench

- Synthesizable AHB-Lite memory slave. It is the DUT-side stage that consumes the master signals driven by the AHB UVC interface and returns hrdata/hready_out/hresp to it.
- Word-organized on-chip RAM with byte-lane writes.
- Programmable wait-state insertion.
- Two-cycle ERROR response for illegal accesses.
- Gives the UVC master agent a real responder for single, burst, wait-state and error scenarios.

---
 rtl/ahb_sram_slave.sv | 140 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
`timescale 1ns/1ps
// AHB-Lite SRAM slave: word RAM with byte-lane writes, programmable wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb_sram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic              hmastlock,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready_in,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready_out,
    output logic              hresp
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [2:0]       size_q, size_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] widx;
    logic [NB-1:0]     lane_en;
    logic              accept, legal, commit;
    logic              unused;

    assign unused = ^{hburst, hprot, hmastlock};

    assign hready_out = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign hresp      = (state_q == S_ERR1) || (state_q == S_ERR2);

    assign widx   = haddr >> OFF_W;
    assign accept = hsel && hready_in && htrans[1] && hready_out;
    assign legal  = (widx < ADDR_W'(DEPTH)) && (hsize <= 3'(OFF_W))
                  && ((haddr & ((ADDR_W'(1) << hsize) - ADDR_W'(1))) == '0);

    // A legal data phase completes on the edge where the FSM sits in IDLE with it pending.
    assign commit = hresetn && pend_q && write_q && (state_q == S_IDLE);
    assign hrdata = (pend_q && !write_q && (state_q == S_IDLE)) ? mem[idx_q] : '0;

    always_comb begin
        lane_en = '0;
        for (int b = 0; b < NB; b++) begin
            lane_en[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        write_d = write_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        if ((state_q == S_IDLE) && pend_q) begin
            pend_d = 1'b0;
        end
        case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: ;
        endcase
        if (accept) begin
            write_d = hwrite;
            idx_d   = widx[IDX_W-1:0];
            off_d   = haddr[OFF_W-1:0];
            size_d  = hsize;
            if (!legal) begin
                state_d = S_ERR1;
                pend_d  = 1'b0;
            end else begin
                pend_d = 1'b1;
                if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
        end
    end

    // RAM contents survive reset; only the lanes of the registered transfer are written.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (lane_en[b]) begin
                    mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
// Scoreboard bench: two slaves (0 and 3 wait states) each driven by a pipelined AHB-Lite
// master; a negedge monitor checks every data phase against a byte-addressed memory model.
module tb_ahb_sram_slave;
    localparam int          DEPTH = 256;
    localparam int unsigned NB    = 4;
    localparam int          WS0   = 0;
    localparam int          WS1   = 3;
    localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SQ = 2'b11;

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
    } xfer_t;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic [1:0]        m_rstn, m_sel, m_write, m_lock;
    logic [1:0][31:0]  m_addr, m_wdata, pend_wd;
    logic [1:0][1:0]   m_trans;
    logic [1:0][2:0]   m_size, m_burst;
    logic [1:0][3:0]   m_prot;
    wire  [1:0]        s_rdy, s_resp;
    wire  [1:0][31:0]  s_rdata;

    logic [1:0] rst_chk;
    logic       drv_done;
    int         drv_to;
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         fin_done = 1'b0;
    int         low_cnt [2] = '{0, 0};
    int         bad_low [2] = '{0, 0};
    logic [7:0] mb [2][1024];
    xfer_t      q0 [$];
    xfer_t      q1 [$];

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(WS0)) u_ws0 (
        .hclk(hclk), .hresetn(m_rstn[0]), .hsel(m_sel[0]), .haddr(m_addr[0]),
        .htrans(m_trans[0]), .hwrite(m_write[0]), .hsize(m_size[0]), .hburst(m_burst[0]),
        .hprot(m_prot[0]), .hmastlock(m_lock[0]), .hwdata(m_wdata[0]), .hready_in(s_rdy[0]),
        .hrdata(s_rdata[0]), .hready_out(s_rdy[0]), .hresp(s_resp[0]));

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(WS1)) u_ws3 (
        .hclk(hclk), .hresetn(m_rstn[1]), .hsel(m_sel[1]), .haddr(m_addr[1]),
        .htrans(m_trans[1]), .hwrite(m_write[1]), .hsize(m_size[1]), .hburst(m_burst[1]),
        .hprot(m_prot[1]), .hmastlock(m_lock[1]), .hwdata(m_wdata[1]), .hready_in(s_rdy[1]),
        .hrdata(s_rdata[1]), .hready_out(s_rdy[1]), .hresp(s_resp[1]));

    // ---------------- reference model ----------------
    function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
        int unsigned bytes;
        bytes = 32'd1 << sz;
        return ((a / NB) < DEPTH) && (bytes <= NB) && ((a % bytes) == 0);
    endfunction

    function automatic logic [31:0] model_rd(input bit e, input logic [31:0] a);
        logic [31:0] w;
        int base;
        base = int'(a - (a % NB));
        for (int j = 0; j < 4; j++) w[8*j +: 8] = mb[e][base + j];
        return w;
    endfunction

    task automatic model_wr(input bit e, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd);
        int off;
        off = int'(a % NB);
        for (int i = 0; i < (1 << sz); i++) mb[e][int'(a) + i] = wd[8*(off + i) +: 8];
    endtask

    // ---------------- scoreboard queue helpers ----------------
    function automatic int qsize(input bit e);
        return e ? q1.size() : q0.size();
    endfunction

    function automatic xfer_t qfront(input bit e);
        return e ? q1[0] : q0[0];
    endfunction

    task automatic qpush(input bit e, input xfer_t t);
        if (e) q1.push_back(t); else q0.push_back(t);
    endtask

    task automatic qdrop(input bit e);
        if (e) void'(q1.pop_front()); else void'(q0.pop_front());
    endtask

    task automatic qflush(input bit e);
        if (e) q1.delete(); else q0.delete();
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string nm, input bit e, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (ws=%0d) at %0t: got %h, want %h", nm, e ? WS1 : WS0,
                     $time, act, exp);
        end
    endtask

    task automatic mon_env(input bit e);
        xfer_t       t;
        logic        act, err;
        int          exp_low;
        logic [31:0] exp_rd;
        if (rst_chk[e]) begin
            check("rst_hready", e, 32'(s_rdy[e]), 32'd1);
            check("rst_hresp", e, 32'(s_resp[e]), 32'd0);
            check("rst_hrdata", e, s_rdata[e], 32'd0);
        end else if (qsize(e) > 0) begin
            t   = qfront(e);
            act = t.sel && t.tr[1];
            err = act && !legal(t.a, t.sz);
            if (!s_rdy[e]) begin
                low_cnt[e]++;
                if ((s_resp[e] !== err) || (s_rdata[e] !== 32'd0)) bad_low[e]++;
                if (low_cnt[e] > 40) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL data_phase_timeout (ws=%0d) addr %h", e ? WS1 : WS0, t.a);
                    qdrop(e);
                    low_cnt[e] = 0;
                    bad_low[e] = 0;
                end
            end else begin
                qdrop(e);
                exp_low = !act ? 0 : (err ? 1 : (e ? WS1 : WS0));
                exp_rd  = (act && !err && !t.wr) ? model_rd(e, t.a) : 32'd0;
                check("hresp", e, 32'(s_resp[e]), 32'(err));
                check("wait_cycles", e, 32'(low_cnt[e]), 32'(exp_low));
                check("low_phase_outputs", e, 32'(bad_low[e]), 32'd0);
                check("hrdata", e, s_rdata[e], exp_rd);
                if (act && !err && t.wr) model_wr(e, t.a, t.sz, t.wd);
                low_cnt[e] = 0;
                bad_low[e] = 0;
            end
        end
    endtask

    always @(negedge hclk) begin
        mon_env(1'b0);
        mon_env(1'b1);
        if (drv_done && !fin_done) begin
            check("driver_stall", 1'b0, 32'(drv_to), 32'd0);
            fin_done = 1'b1;
        end
    end

    // ---------------- master driver ----------------
    task automatic xfer(input bit e, input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [2:0] bst, input logic [31:0] a,
                        input logic [31:0] wd);
        xfer_t t;
        logic  rdy;
        int    guard;
        m_wdata[e] = pend_wd[e];
        m_sel[e]   = sel;
        m_trans[e] = tr;
        m_write[e] = wr;
        m_size[e]  = sz;
        m_burst[e] = bst;
        m_addr[e]  = a;
        m_prot[e]  = 4'($urandom);
        m_lock[e]  = 1'($urandom);
        guard = 0;
        forever begin
            @(negedge hclk);
            rdy = s_rdy[e];
            @(posedge hclk);
            if (rdy) break;
            guard++;
            if (guard > 40) begin
                drv_to++;
                break;
            end
        end
        #1;
        t = '{sel, tr, wr, sz, a, wd};
        qpush(e, t);
        pend_wd[e] = wr ? wd : 32'd0;
    endtask

    task automatic do_reset(input bit e, input int cycles);
        m_wdata[e] = pend_wd[e];
        m_sel[e]   = 1'b0;
        m_trans[e] = T_IDLE;
        m_rstn[e]  = 1'b0;
        qflush(e);
        pend_wd[e] = 32'd0;
        repeat (cycles) begin
            @(posedge hclk);
            #1;
            rst_chk[e] = 1'b1;
        end
        m_rstn[e]  = 1'b1;
        rst_chk[e] = 1'b0;
    endtask

    task automatic run_env(input bit e);
        logic [2:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) xfer(e, 1, (i == 0) ? T_NS : T_SQ, 1, 2, 3'b001, 32'(4 * i), 0);
        // Reset lands in the data phase of this write, so it must never reach the RAM.
        xfer(e, 1, T_NS, 1, 2, 0, 32'h10, 32'hDEADBEEF);
        do_reset(e, 3);
        xfer(e, 1, T_NS, 0, 2, 0, 32'h10, 0);
        xfer(e, 1, T_NS, 1, 2, 0, 32'h20, 32'hCAFEF00D);
        xfer(e, 1, T_NS, 0, 2, 0, 32'h20, 0);
        xfer(e, 1, T_NS, 1, 2, 0, 32'h40, 32'h11223344);
        xfer(e, 1, T_NS, 1, 0, 0, 32'h41, 32'hABABABAB);
        xfer(e, 1, T_NS, 0, 2, 0, 32'h40, 0);
        for (int i = 0; i < 4; i++) xfer(e, 1, (i == 0) ? T_NS : T_SQ, 1, 2, 3'b011, 32'h80 + 32'(4 * i), $urandom);
        for (int i = 0; i < 4; i++) xfer(e, 1, (i == 0) ? T_NS : T_SQ, 0, 2, 3'b011, 32'h80 + 32'(4 * i), 0);
        xfer(e, 1, T_NS, 0, 2, 0, 32'h400, 0);
        xfer(e, 1, T_NS, 1, 2, 0, 32'h02, 32'h5A5A5A5A);
        xfer(e, 1, T_NS, 0, 2, 0, 32'h00, 0);
        xfer(e, 1, T_NS, 1, 2, 3'b001, 32'h90, $urandom);
        xfer(e, 1, T_BUSY, 1, 2, 3'b001, 32'h94, $urandom);
        xfer(e, 1, T_SQ, 1, 2, 3'b001, 32'h94, $urandom);
        xfer(e, 1, T_IDLE, 1, 2, 3'b001, 32'h98, $urandom);
        xfer(e, 0, T_NS, 1, 2, 3'b001, 32'h9C, $urandom);
        xfer(e, 1, T_NS, 1, 2, 3'b001, 32'h98, $urandom);
        for (int i = 0; i < 4; i++) xfer(e, 1, T_NS, 0, 2, 0, 32'h90 + 32'(4 * i), 0);
        repeat (90) begin
            sz = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 14) == 0) a = a + 32'h400;
            xfer(e, $urandom_range(0, 11) != 0,
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
                 1'($urandom), sz, 3'($urandom), a, $urandom);
        end
        repeat (3) xfer(e, 1, T_IDLE, 0, 2, 0, 0, 0);
    endtask

    initial begin
        m_rstn   = '0;
        m_sel    = '0;
        m_write  = '0;
        m_lock   = '0;
        m_addr   = '0;
        m_wdata  = '0;
        pend_wd  = '0;
        m_trans  = '0;
        m_size   = '0;
        m_burst  = '0;
        m_prot   = '0;
        rst_chk  = '0;
        drv_done = 1'b0;
        drv_to   = 0;
        do_reset(1'b0, 3);
        do_reset(1'b1, 3);
        run_env(1'b0);
        run_env(1'b1);
        for (int i = 0; i < 50 && (q0.size() + q1.size()) > 0; i++) @(posedge hclk);
        drv_done = 1'b1;
        repeat (3) @(posedge hclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
